sub_bytes_iter: RTL and testbench

- Sequential forward AES SubBytes engine; the encrypt-direction counterpart of the combinational inverse substitution stage.
- Accepts one `size`-byte block over a ready/valid input and substitutes `lanes` bytes per cycle through `lanes` S-box instances.
- Presents the result over a valid/yumi output.
- Sits between AddRoundKey and ShiftRows in the iterative encrypt datapath; trades latency for S-box area.

---
 rtl/sub_bytes_iter.sv | 175 +++++++++++++++++
 tb/tb_sub_bytes_iter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes engine.
// Takes one size-byte block over ready/valid, substitutes `lanes` bytes per
// cycle in place, and offers the result over valid/yumi.
// Optional build macro SUB_BYTES_INV_EN adds inv_i and inverse S-box ROMs.
//
// state | meaning
// IDLE  | waiting for a block, ready_o=1
// BUSY  | substituting one chunk of `lanes` bytes per cycle
// DONE  | result offered on v_o until yumi_i
module sub_bytes_iter #(
    parameter int size  = 16,
    parameter int lanes = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              v_i,
    output logic              ready_o,
    input  logic [size*8-1:0] block_i,
`ifdef SUB_BYTES_INV_EN
    input  logic              inv_i,
`endif
    output logic              v_o,
    input  logic              yumi_i,
    output logic [size*8-1:0] subed_block_o
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;

    if (lanes < 1 || lanes > size || (size % lanes) != 0) begin : g_bad_params
        $error("sub_bytes_iter: lanes must divide size and lie in 1..size");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_count;
    logic [size*8-1:0]   r_work;
    logic [size*8-1:0]   w_work_next;
    logic                w_accept;
    logic                w_last;
    logic [7:0]          w_lane_in  [lanes];
    logic [7:0]          w_lane_out [lanes];
`ifdef SUB_BYTES_INV_EN
    logic                r_inv;
`endif

    // Row-per-case forward S-box ROM; the low nibble picks the byte in the row.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [127:0] row;
        case (a[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[{~a[3:0], 3'b000} +: 8];
    endfunction

`ifdef SUB_BYTES_INV_EN
    // Inverse S-box ROM, same row layout as the forward table.
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [127:0] row;
        case (a[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[{~a[3:0], 3'b000} +: 8];
    endfunction
`endif

    assign w_last = (r_count == CW'(size - lanes));

    // One S-box per lane, fed from the chunk selected by r_count.
    for (genvar l = 0; l < lanes; l++) begin : g_lane
        assign w_lane_in[l] = r_work[(size - 1 - l - int'(r_count)) * 8 +: 8];
`ifdef SUB_BYTES_INV_EN
        assign w_lane_out[l] = r_inv ? sbox_inv(w_lane_in[l]) : sbox_fwd(w_lane_in[l]);
`else
        assign w_lane_out[l] = sbox_fwd(w_lane_in[l]);
`endif
    end

    // Merge the substituted chunk back into its byte positions.
    always_comb begin
        w_work_next = r_work;
        for (int l = 0; l < lanes; l++) begin
            w_work_next[(size - 1 - l - int'(r_count)) * 8 +: 8] = w_lane_out[l];
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        v_o          = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: if (w_last) w_state_next = DONE;
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Work register and chunk counter; count holds on the last chunk so it never wraps.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
            r_work  <= '0;
`ifdef SUB_BYTES_INV_EN
            r_inv   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_count <= '0;
            r_work  <= block_i;
`ifdef SUB_BYTES_INV_EN
            r_inv   <= inv_i;
`endif
        end else if (r_state == BUSY) begin
            r_work <= w_work_next;
            if (!w_last) r_count <= r_count + CW'(lanes);
        end
    end

    assign subed_block_o = r_work;

`ifndef SYNTHESIS
    // yumi_i is only meaningful while a result is being offered.
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("sub_bytes_iter: yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: GF(2^8)-derived S-box model, per-cycle compare,
// directed scenarios followed by randomized traffic.
module tb_sub_bytes_iter;
    localparam int SIZE  = 16;
    localparam int LANES = 4;
    localparam int NCH   = SIZE / LANES;
    localparam int W     = SIZE * 8;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] block_i;
    logic         v_o;
    logic         yumi_i;
    logic [W-1:0] subed_block_o;
`ifdef SUB_BYTES_INV_EN
    logic         inv_i;
`endif

    sub_bytes_iter #(.size(SIZE), .lanes(LANES)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .block_i       (block_i),
`ifdef SUB_BYTES_INV_EN
        .inv_i         (inv_i),
`endif
        .v_o           (v_o),
        .yumi_i        (yumi_i),
        .subed_block_o (subed_block_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_sbox  [256];
    logic [7:0] m_isbox [256];

    // model: phase 0=idle 1=busy 2=done
    int           m_phase;
    int           m_chunks;
    logic [W-1:0] m_src;
    logic         m_inv;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15 - n -: 8];
    endfunction

    function automatic void build_tables();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            m_sbox[a] = s;
        end
        for (int a = 0; a < 256; a++) m_isbox[m_sbox[a]] = 8'(a);
    endfunction

    // first n*LANES bytes (MSB first) substituted, the rest untouched
    function automatic logic [W-1:0] partial(input logic [W-1:0] src, input int n, input logic inv);
        logic [W-1:0] r = src;
        for (int i = 0; i < n * LANES; i++) begin
            logic [7:0] b = src[(SIZE - 1 - i) * 8 +: 8];
            r[(SIZE - 1 - i) * 8 +: 8] = inv ? m_isbox[b] : m_sbox[b];
        end
        return r;
    endfunction

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_chunks = 0; m_src = '0; m_inv = 1'b0;
    endfunction

    function automatic void check_outputs();
        chk("ready_o", W'(ready_o), W'(m_phase == 0));
        chk("v_o", W'(v_o), W'(m_phase == 2));
        chk("subed_block_o", subed_block_o, partial(m_src, m_chunks, m_inv));
    endfunction

    // advance one clock: model consumes the inputs present at the edge
    task automatic step();
        @(posedge clk_i);
        if (reset_i) model_reset();
        else begin
            case (m_phase)
                0: if (v_i) begin
                    m_src = block_i; m_chunks = 0; m_phase = 1;
`ifdef SUB_BYTES_INV_EN
                    m_inv = inv_i;
`endif
                end
                1: begin
                    m_chunks++;
                    if (m_chunks == NCH) m_phase = 2;
                end
                default: if (yumi_i) m_phase = 0;
            endcase
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic wait_vo(output int cyc);
        cyc = 0;
        while (!v_o && cyc < 50) begin
            v_i = 1'b0; yumi_i = 1'b0;
            step();
            cyc++;
        end
        if (!v_o) begin
            checks++; errors++;
            $display("FAIL wait_v_o: timeout after %0d cycles, v_o=%b expected 1", cyc, v_o);
        end
    endtask

    task automatic accept(input logic [W-1:0] blk, input logic inv);
        v_i = 1'b1; block_i = blk; yumi_i = 1'b0;
`ifdef SUB_BYTES_INV_EN
        inv_i = inv;
`else
        if (inv) $display("note: inverse requested in forward-only build");
`endif
        step();
        v_i = 1'b0;
    endtask

    task automatic take();
        yumi_i = v_o;
        step();
        yumi_i = 1'b0;
    endtask

    task automatic run_block(input logic [W-1:0] blk, input logic inv, input logic [W-1:0] exp, input string name);
        int cyc;
        accept(blk, inv);
        wait_vo(cyc);
        chk({name, "_latency"}, W'(cyc), W'(NCH));
        chk(name, subed_block_o, exp);
        take();
    endtask

    localparam logic [W-1:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [W-1:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        int cyc;
        logic [W-1:0] ones, ffs, sixes, zeros, c63, c7c;
        zeros = '0;
        for (int i = 0; i < SIZE; i++) begin
            ones[i*8 +: 8] = 8'h01; ffs[i*8 +: 8] = 8'hff; sixes[i*8 +: 8] = 8'h16;
            c63[i*8 +: 8] = 8'h63;  c7c[i*8 +: 8] = 8'h7c;
        end
        build_tables();
        // pin the model against known S-box entries and the FIPS-197 round-1 state
        chk("model_sbox_00", W'(m_sbox[0]), W'(8'h63));
        chk("model_sbox_ff", W'(m_sbox[255]), W'(8'h16));
        chk("model_sbox_01", W'(m_sbox[1]), W'(8'h7c));
        chk("model_fips", partial(FIPS_IN, NCH, 1'b0), FIPS_OUT);
        chk("model_isbox_63", W'(m_isbox[8'h63]), W'(8'h00));

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; block_i = '0;
`ifdef SUB_BYTES_INV_EN
        inv_i = 1'b0;
`endif
        model_reset();
        @(negedge clk_i);
        check_outputs();
        step();
        reset_i = 1'b0;
        step();

        // FIPS vector, result taken immediately
        run_block(FIPS_IN, 1'b0, FIPS_OUT, "fips");
        chk("ready_after_take", W'(ready_o), W'(1));
        chk("retained_after_take", subed_block_o, FIPS_OUT);

        run_block(zeros, 1'b0, c63, "zeros");
        run_block(ffs, 1'b0, sixes, "ffs");

        // backpressure: hold yumi low for 6 cycles
        accept(FIPS_IN, 1'b0);
        wait_vo(cyc);
        for (int i = 0; i < 6; i++) step();
        chk("bp_held", subed_block_o, FIPS_OUT);
        take();

        // v_i during BUSY must be ignored
        accept(FIPS_IN, 1'b0);
        v_i = 1'b1; block_i = ones;
        step(); step();
        v_i = 1'b0;
        wait_vo(cyc);
        chk("busy_vi_ignored", subed_block_o, FIPS_OUT);
        take();
        run_block(ones, 1'b0, c7c, "ones");

        // async reset two cycles into BUSY
        accept(FIPS_IN, 1'b0);
        step(); step();
        reset_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_v_o", W'(v_o), W'(0));
        chk("rst_ready_o", W'(ready_o), W'(1));
        chk("rst_data", subed_block_o, zeros);
        step();
        reset_i = 1'b0;
        step();
        run_block(zeros, 1'b0, c63, "after_reset");

`ifdef SUB_BYTES_INV_EN
        run_block(FIPS_OUT, 1'b1, FIPS_IN, "inv_fips");
        run_block(c63, 1'b1, zeros, "inv_63");
        run_block(FIPS_IN, 1'b0, FIPS_OUT, "fwd_in_inv_build");
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_i = 1'b1;
                #1;
                model_reset();
                check_outputs();
                step();
                reset_i = 1'b0;
            end
            v_i = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0: block_i = zeros;
                1: block_i = ffs;
                default: for (int b = 0; b < SIZE; b++) block_i[b*8 +: 8] = 8'($urandom);
            endcase
`ifdef SUB_BYTES_INV_EN
            inv_i = 1'($urandom);
`endif
            yumi_i = v_o && ($urandom_range(0, 1) == 1);
            step();
        end
        v_i = 1'b0; yumi_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end
endmodule
